// File: rtl/uart_pkg.sv
// Shared types and constants for the UART bus responder.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_bus_responder.sv
// Device side of the CPU parallel UART bus: 8N1 transmitter and receiver behind rdn/wrn strobes.
// Define UART_LOOPBACK_EN to feed the receiver from the internal txd instead of the rxd pin.
module uart_bus_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rdn,
    input  logic       wrn,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    input  logic       rxd,
    output logic       txd
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    logic txd_reg, txd_next;
    logic rx_src;

`ifdef UART_LOOPBACK_EN
    assign rx_src = txd_reg;
`else
    assign rx_src = rxd;
`endif

    // Synchronizers: bit 0 = rdn, bit 1 = wrn, bit 2 = serial receive input
    logic [2:0] sync_in;
    logic [2:0] sync_out;
    assign sync_in = {rx_src, wrn, rdn};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
                .CLK (CLK),
                .RST (RST),
                .d   (sync_in[gi]),
                .q   (sync_out[gi])
            );
        end
    endgenerate

    logic rd_s, wr_s, rx_s;
    assign rd_s = sync_out[0];
    assign wr_s = sync_out[1];
    assign rx_s = sync_out[2];

    // Registered edge pulses give a fixed, glitch-free strobe to the datapath
    logic rd_d_reg, wr_d_reg, rd_rise_reg, wr_fall_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_d_reg    <= 1'b1;
            wr_d_reg    <= 1'b1;
            rd_rise_reg <= 1'b0;
            wr_fall_reg <= 1'b0;
        end else begin
            rd_d_reg    <= rd_s;
            wr_d_reg    <= wr_s;
            rd_rise_reg <= ~rd_d_reg & rd_s;
            wr_fall_reg <= wr_d_reg & ~wr_s;
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]    tx_bit_reg, tx_bit_next;
    logic [7:0]    tx_shift_reg, tx_shift_next;
    logic [7:0]    thr_reg, thr_next;
    logic          thr_full_reg, thr_full_next;
    logic          tsre_reg, tsre_next;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        thr_next      = thr_reg;
        thr_full_next = thr_full_reg;
        tsre_next     = tsre_reg;
        txd_next      = txd_reg;

        if (wr_fall_reg && !thr_full_reg) begin
            thr_next      = data_in;
            thr_full_next = 1'b1;
        end

        case (tx_state_reg)
            TX_IDLE: begin
                txd_next = 1'b1;
                if (thr_full_reg) begin
                    tx_shift_next = thr_reg;
                    thr_full_next = 1'b0;
                    tsre_next     = 1'b0;
                    tx_cnt_next   = '0;
                    txd_next      = 1'b0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    txd_next      = tx_shift_reg[0];
                    tx_state_next = TX_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == BIT_LAST) begin
                        txd_next      = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 1'b1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        txd_next      = tx_shift_reg[1];
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next = '0;
                    // A byte already waiting starts right away, with no idle bit
                    if (thr_full_reg) begin
                        tx_shift_next = thr_reg;
                        thr_full_next = 1'b0;
                        txd_next      = 1'b0;
                        tx_state_next = TX_START;
                    end else begin
                        tsre_next     = 1'b1;
                        tx_state_next = TX_IDLE;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            thr_reg      <= '0;
            thr_full_reg <= 1'b0;
            tsre_reg     <= 1'b1;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            thr_reg      <= thr_next;
            thr_full_reg <= thr_full_next;
            tsre_reg     <= tsre_next;
            txd_reg      <= txd_next;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]    rx_bit_reg, rx_bit_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic          rx_done_reg, rx_done_next;
    logic          rx_stop_reg, rx_stop_next;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_done_next  = 1'b0;
        rx_stop_next  = rx_stop_reg;

        case (rx_state_reg)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                // Half-bit re-check rejects glitches and aligns later samples to mid-bit
                if (rx_cnt_reg == CNT_HALF) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_s, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 1'b1;
                    if (rx_bit_reg == BIT_LAST) begin
                        rx_state_next = RX_STOP;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_done_next  = 1'b1;
                    rx_stop_next  = rx_s;
                    rx_state_next = RX_IDLE;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_done_reg  <= 1'b0;
            rx_stop_reg  <= 1'b1;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_done_reg  <= rx_done_next;
            rx_stop_reg  <= rx_stop_next;
        end
    end

    // Holding register and status; a read clear in the same cycle frees the slot for a new byte
    logic [7:0] hold_reg;
    logic       data_ready_reg, overrun_reg, frame_err_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_reg       <= '0;
            data_ready_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            if (rd_rise_reg) begin
                data_ready_reg <= 1'b0;
                overrun_reg    <= 1'b0;
                frame_err_reg  <= 1'b0;
            end
            if (rx_done_reg) begin
                if (rx_stop_reg) begin
                    if (!data_ready_reg || rd_rise_reg) begin
                        hold_reg       <= rx_shift_reg;
                        data_ready_reg <= 1'b1;
                    end else begin
                        overrun_reg <= 1'b1;
                    end
                end else begin
                    frame_err_reg <= 1'b1;
                end
            end
        end
    end

    assign data_out     = hold_reg;
    assign data_oe      = ~rdn;
    assign data_ready   = data_ready_reg;
    assign tbre         = ~thr_full_reg;
    assign tsre         = tsre_reg;
    assign rx_overrun   = overrun_reg;
    assign rx_frame_err = frame_err_reg;
    assign txd          = txd_reg;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench for uart_bus_responder at 16 clocks per bit; TX is checked every cycle
// against a frame-timeline model, RX at frame-level checkpoints.
module tb_uart_bus_responder;

    localparam int CPB = 16;
    localparam int FRAME = 10 * CPB;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rdn, wrn, rxd;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe, data_ready, tbre, tsre, rx_overrun, rx_frame_err, txd;

    uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .rdn          (rdn),
        .wrn          (wrn),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .data_ready   (data_ready),
        .tbre         (tbre),
        .tsre         (tsre),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .rxd          (rxd),
        .txd          (txd)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // TX model: each accepted byte becomes a frame with an accept cycle and a start cycle
    typedef struct {
        int         acc;
        int         start;
        logic [7:0] b;
    } frame_t;
    frame_t frames[$];

    function automatic logic exp_txd(int t);
        foreach (frames[i]) begin
            if (t >= frames[i].start && t < frames[i].start + FRAME) begin
                int bi = (t - frames[i].start) / CPB;
                if (bi == 0) return 1'b0;
                if (bi == 9) return 1'b1;
                return frames[i].b[bi-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_tsre(int t);
        foreach (frames[i])
            if (t >= frames[i].start && t < frames[i].start + FRAME) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_tbre(int t);
        foreach (frames[i])
            if (t >= frames[i].acc && t < frames[i].start) return 1'b0;
        return 1'b1;
    endfunction

    // A write strobe takes effect at cycle a; it is kept only if the holding register was empty at a-1
    function automatic void model_write(int a, logic [7:0] b);
        frame_t f;
        int     prev_end;
        if (frames.size() != 0 && frames[$].start > a - 1) return;
        prev_end = (frames.size() == 0) ? 0 : frames[$].start + FRAME;
        f.acc   = a;
        f.start = (a + 1 > prev_end) ? a + 1 : prev_end;
        f.b     = b;
        frames.push_back(f);
    endfunction

    always @(negedge CLK) begin
        if (chk_en && !RST) begin
            chk("txd", 32'(txd), 32'(exp_txd(cyc)));
            chk("tsre", 32'(tsre), 32'(exp_tsre(cyc)));
            chk("tbre", 32'(tbre), 32'(exp_tbre(cyc)));
        end
    end

    // RX model at the level of whole frames
    logic [7:0] m_hr;
    logic       m_dr, m_ovr, m_ferr;

    task automatic rx_model_reset();
        m_hr = 8'h00; m_dr = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic rx_model(input logic [7:0] b, input logic stop);
        if (!stop) m_ferr = 1'b1;
        else if (m_dr) m_ovr = 1'b1;
        else begin
            m_hr = b;
            m_dr = 1'b1;
        end
    endtask

    task automatic at_cyc(input int t);
        do @(negedge CLK); while (cyc < t);
    endtask

    task automatic check_rx(input string tag);
        @(negedge CLK);
        chk({tag, ".data_ready"}, 32'(data_ready), 32'(m_dr));
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_hr));
        chk({tag, ".overrun"}, 32'(rx_overrun), 32'(m_ovr));
        chk({tag, ".frame_err"}, 32'(rx_frame_err), 32'(m_ferr));
    endtask

    task automatic do_write(input logic [7:0] b, output int k);
        @(posedge CLK);
        #2;
        wrn = 1'b0;
        data_in = b;
        k = cyc + 1;
        model_write(k + 3, b);
        fork
            begin
                repeat (6) @(posedge CLK);
                #2 wrn = 1'b1;
            end
        join_none
    endtask

    task automatic do_read(input string tag);
        int r;
        @(posedge CLK);
        #2 rdn = 1'b0;
        @(negedge CLK);
        chk({tag, ".data_oe_low"}, 32'(data_oe), 32'd1);
        chk({tag, ".read_val"}, 32'(data_out), 32'(m_hr));
        repeat (4) @(posedge CLK);
        #2 rdn = 1'b1;
        r = cyc + 1;
        at_cyc(r + 2);
        chk({tag, ".dr_before_clear"}, 32'(data_ready), 32'(m_dr));
        chk({tag, ".data_oe_high"}, 32'(data_oe), 32'd0);
        at_cyc(r + 3);
        chk({tag, ".dr_cleared"}, 32'(data_ready), 32'd0);
        m_dr = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        check_rx(tag);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #2 rxd = bits[i];
            repeat (CPB - 1) @(posedge CLK);
        end
        @(posedge CLK);
        #2 rxd = 1'b1;
        repeat (24) @(posedge CLK);
        rx_model(b, stop);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int k, k1, k2, k3;
    int a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        RST = 1'b1; rdn = 1'b0; wrn = 1'b1; rxd = 1'b1; data_in = 8'h00;
        rx_model_reset();
        repeat (2) @(negedge CLK);
        chk("rst.txd", 32'(txd), 32'd1);
        chk("rst.tbre", 32'(tbre), 32'd1);
        chk("rst.tsre", 32'(tsre), 32'd1);
        chk("rst.data_ready", 32'(data_ready), 32'd0);
        chk("rst.data_out", 32'(data_out), 32'h00);
        chk("rst.overrun", 32'(rx_overrun), 32'd0);
        chk("rst.frame_err", 32'(rx_frame_err), 32'd0);
        chk("rst.data_oe_low", 32'(data_oe), 32'd1);
        rdn = 1'b1;
        #1 chk("rst.data_oe_high", 32'(data_oe), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(posedge CLK);

        // Reset in the middle of a data bit
        do_write(8'hC3, k);
        at_cyc(k + 4 + CPB * 3 + 8);
        chk("midrst.tsre_busy", 32'(tsre), 32'd0);
        chk_en = 1'b0;
        #1 RST = 1'b1;
        #1;
        chk("midrst.txd", 32'(txd), 32'd1);
        chk("midrst.tbre", 32'(tbre), 32'd1);
        chk("midrst.tsre", 32'(tsre), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        frames.delete();
        rx_model_reset();
        chk_en = 1'b1;
        repeat (8) @(posedge CLK);

        // Single byte with pinned bit timing
        do_write(8'hA5, k);
        at_cyc(k + 2);
        chk("a5.tbre_k2", 32'(tbre), 32'd1);
        at_cyc(k + 3);
        chk("a5.tbre_k3", 32'(tbre), 32'd0);
        at_cyc(k + 4);
        chk("a5.tbre_k4", 32'(tbre), 32'd1);
        chk("a5.tsre_k4", 32'(tsre), 32'd0);
        chk("a5.start_k4", 32'(txd), 32'd0);
        for (int i = 0; i < 10; i++) begin
            at_cyc(k + 4 + CPB * i + 8);
            chk($sformatf("a5.bit%0d", i), 32'(txd), 32'(a5_bits[i]));
        end
        at_cyc(k + 4 + FRAME - 1);
        chk("a5.tsre_last", 32'(tsre), 32'd0);
        at_cyc(k + 4 + FRAME);
        chk("a5.tsre_end", 32'(tsre), 32'd1);
        repeat (20) @(posedge CLK);
`ifdef UART_LOOPBACK_EN
        rx_model(8'hA5, 1'b1);
`endif

        // Back-to-back writes; the third arrives while the holding register is full
        do_write(8'h01, k1);
        at_cyc(k1 + 40);
        do_write(8'h02, k2);
        at_cyc(k2 + 20);
        do_write(8'h03, k3);
        at_cyc(k1 + 4 + FRAME);
        chk("b2b.tsre_gapless", 32'(tsre), 32'd0);
        chk("b2b.start2", 32'(txd), 32'd0);
        at_cyc(k1 + 4 + 2 * FRAME + 6);
        chk("b2b.third_dropped", 32'(tsre), 32'd1);
        repeat (20) @(posedge CLK);

`ifdef UART_LOOPBACK_EN
        rx_model(8'h01, 1'b1);
        rx_model(8'h02, 1'b1);
        check_rx("lb_b2b");
        do_read("lb_rd");
        do_write(8'h5A, k);
        at_cyc(k + 4 + FRAME + 10);
        rx_model(8'h5A, 1'b1);
        check_rx("lb_5a");
        chk("lb_5a.data_out_lit", 32'(data_out), 32'h5A);
        chk("lb_5a.dr_lit", 32'(data_ready), 32'd1);
`else
        send_frame(8'h3C, 1'b1);
        check_rx("rx_3c");
        chk("rx_3c.data_out_lit", 32'(data_out), 32'h3C);
        chk("rx_3c.dr_lit", 32'(data_ready), 32'd1);
        do_read("rd_3c");

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check_rx("rx_ovr");
        chk("rx_ovr.data_out_lit", 32'(data_out), 32'h11);
        chk("rx_ovr.overrun_lit", 32'(rx_overrun), 32'd1);
        do_read("rd_ovr");

        send_frame(8'h44, 1'b0);
        check_rx("rx_ferr");
        chk("rx_ferr.frame_err_lit", 32'(rx_frame_err), 32'd1);
        chk("rx_ferr.dr_lit", 32'(data_ready), 32'd0);
        do_read("rd_ferr");

        @(posedge CLK);
        #2 rxd = 1'b0;
        repeat (5) @(posedge CLK);
        #2 rxd = 1'b1;
        repeat (200) @(posedge CLK);
        check_rx("glitch");
        chk("glitch.dr_lit", 32'(data_ready), 32'd0);
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
